// File: rtl/multi_cycle.sv
// Multicycle weighted-sum unit: S = sum(i * indata_i) using one shared adder,
// then double-dabble to three BCD digits plus sign for a seven-segment driver.
module multi_cycle (
  input  logic       clk,
  input  logic       resetN,
  input  logic       haltN,
  input  logic [7:0] indata1,
  input  logic [7:0] indata2,
  input  logic [7:0] indata3,
  input  logic [7:0] indata4,
  input  logic [7:0] indata5,
  input  logic [7:0] indata6,
  input  logic [7:0] indata7,
  output logic       error,
  output logic [3:0] seven_seg_sign,
  output logic [3:0] seven_seg_digit_1,
  output logic [3:0] seven_seg_digit_2,
  output logic [3:0] seven_seg_digit_3,
  output logic       finish_flag
);

  typedef enum logic [2:0] {LOAD, ADD_T, ADD_S, CHECK, CONV, DONE} state_t;

  state_t             state, state_nxt;
  logic [7:1][7:0]    din;
  logic signed [15:0] x [1:7];
  logic signed [15:0] t_acc, s_acc, abs_s;
  logic [2:0]         idx;
  logic [3:0]         conv_cnt;
  logic [11:0]        mag;
  logic               neg, ovf;
  logic [27:0]        dd, dd_adj;

  always_comb begin
    din[1] = indata1;
    din[2] = indata2;
    din[3] = indata3;
    din[4] = indata4;
    din[5] = indata5;
    din[6] = indata6;
    din[7] = indata7;
  end

  always_comb abs_s = s_acc[15] ? -s_acc : s_acc;

  // dd = {thousands, hundreds, tens, units, binary}; correct each BCD nibble before the shift
  always_comb begin
    dd_adj = dd;
    for (int unsigned n = 0; n < 4; n++) begin
      if (dd[12 + 4*n +: 4] >= 4'd5)
        dd_adj[12 + 4*n +: 4] = dd[12 + 4*n +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = ADD_T;
      ADD_T:   state_nxt = ADD_S;
      ADD_S:   state_nxt = (idx == 3'd1) ? CHECK : ADD_T;
      CHECK:   state_nxt = CONV;
      CONV:    state_nxt = (conv_cnt == 4'd11) ? DONE : CONV;
      DONE:    state_nxt = DONE;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetN)
      state <= LOAD;
    else if (haltN)
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      for (int unsigned k = 1; k <= 7; k++) x[k] <= '0;
      t_acc             <= '0;
      s_acc             <= '0;
      idx               <= 3'd7;
      conv_cnt          <= '0;
      mag               <= '0;
      neg               <= 1'b0;
      ovf               <= 1'b0;
      dd                <= '0;
      error             <= 1'b0;
      finish_flag       <= 1'b0;
      seven_seg_sign    <= 4'd14;
      seven_seg_digit_1 <= '0;
      seven_seg_digit_2 <= '0;
      seven_seg_digit_3 <= '0;
    end else if (haltN) begin
      case (state)
        LOAD: begin
          for (int unsigned k = 1; k <= 7; k++)
            x[k] <= {{8{din[k][7]}}, din[k]};
          t_acc <= '0;
          s_acc <= '0;
          idx   <= 3'd7;
        end
        ADD_T: t_acc <= t_acc + x[idx];
        // Suffix sums: x_i joins T at step i and is then added into S i times.
        ADD_S: begin
          s_acc <= s_acc + t_acc;
          if (idx != 3'd1) idx <= idx - 3'd1;
        end
        CHECK: begin
          mag      <= abs_s[11:0];
          neg      <= s_acc[15];
          ovf      <= (abs_s > 16'sd999);
          dd       <= {16'b0, abs_s[11:0]};
          conv_cnt <= '0;
        end
        CONV: begin
          dd       <= dd_adj << 1;
          conv_cnt <= conv_cnt + 4'd1;
        end
        DONE: begin
          if (!finish_flag) begin
            finish_flag <= 1'b1;
            if (ovf) begin
              error             <= 1'b1;
              seven_seg_sign    <= 4'd14;
              seven_seg_digit_1 <= 4'd14;
              seven_seg_digit_2 <= 4'd14;
              seven_seg_digit_3 <= 4'd14;
            end else begin
              error             <= 1'b0;
              seven_seg_sign    <= (neg && mag != '0) ? 4'd15 : 4'd14;
              seven_seg_digit_1 <= dd[23:20];
              seven_seg_digit_2 <= dd[19:16];
              seven_seg_digit_3 <= dd[15:12];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle.sv
// Scoreboard bench for multi_cycle: stimulus pushes expected results, a monitor
// pops and compares on each rising edge of finish_flag.
module tb_multi_cycle;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       haltN = 1'b1;
  logic [7:0] indata1, indata2, indata3, indata4, indata5, indata6, indata7;
  logic       error, finish_flag;
  logic [3:0] seven_seg_sign, seven_seg_digit_1, seven_seg_digit_2, seven_seg_digit_3;

  multi_cycle dut (
    .clk(clk), .resetN(resetN), .haltN(haltN),
    .indata1(indata1), .indata2(indata2), .indata3(indata3), .indata4(indata4),
    .indata5(indata5), .indata6(indata6), .indata7(indata7),
    .error(error), .seven_seg_sign(seven_seg_sign),
    .seven_seg_digit_1(seven_seg_digit_1), .seven_seg_digit_2(seven_seg_digit_2),
    .seven_seg_digit_3(seven_seg_digit_3), .finish_flag(finish_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [3:0] sg, d1, d2, d3;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc_cnt = 0;

  always @(posedge clk) begin
    if (resetN) cyc_cnt <= 0;
    else        cyc_cnt <= cyc_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act == exp_v) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endtask

  // Monitor
  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (finish_flag && !prev) begin
        if (q.size() == 0) begin
          chk("unexpected_finish", 1, 0);
        end else begin
          e = q.pop_front();
          chk("latency",  cyc_cnt,           e.cyc);
          chk("error",    error,             e.err);
          chk("sign",     seven_seg_sign,    e.sg);
          chk("digit_1",  seven_seg_digit_1, e.d1);
          chk("digit_2",  seven_seg_digit_2, e.d2);
          chk("digit_3",  seven_seg_digit_3, e.d3);
        end
      end
      prev = finish_flag;
    end
  end

  task automatic apply(input logic [6:0][7:0] v);
    indata1 = v[0]; indata2 = v[1]; indata3 = v[2]; indata4 = v[3];
    indata5 = v[4]; indata6 = v[5]; indata7 = v[6];
  endtask

  task automatic wait_done();
    int k = 0;
    while (!finish_flag && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (!finish_flag) chk("finish_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_finish"}, finish_flag, 0);
    chk({tag, "_error"},  error, 0);
    chk({tag, "_sign"},   seven_seg_sign, 14);
    chk({tag, "_digits"}, {seven_seg_digit_1, seven_seg_digit_2, seven_seg_digit_3}, 0);
  endtask

  task automatic run(input logic [6:0][7:0] v, input logic e, input logic [3:0] sg,
                     input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
                     input int halt_at);
    exp_t ex;
    apply(v);
    resetN = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ex.err = e; ex.sg = sg; ex.d1 = d1; ex.d2 = d2; ex.d3 = d3;
    ex.cyc = (halt_at > 0) ? 34 : 29;
    q.push_back(ex);
    resetN = 1'b0;
    if (halt_at > 0) begin
      repeat (halt_at - 1) @(posedge clk);
      #1 haltN = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("halt_finish", finish_flag, 0);
      chk("halt_sign", seven_seg_sign, 14);
      haltN = 1'b1;
    end else begin
      repeat (5) @(posedge clk);
      #1 apply(~v);
      repeat (15) @(posedge clk);
      #1 check_reset_vals("prefinish");
    end
    wait_done();
  endtask

  initial begin
    apply('0);
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");

    run({8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd105}, 1'b0, 4'd14, 4'd1, 4'd0, 4'd5, 0);
    run({7{8'd1}},                                   1'b0, 4'd14, 4'd0, 4'd2, 4'd8, 0);
    run({8'hFF, 8'd0, 8'h9C, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 4'd15, 4'd5, 4'd0, 4'd7, 0);
    run({7{8'd127}},                                 1'b1, 4'd14, 4'd14, 4'd14, 4'd14, 0);
    run({7{8'h80}},                                  1'b1, 4'd14, 4'd14, 4'd14, 4'd14, 0);
    // 7*127 + 5*22 = 999 (in range), +1 gives 1000 (overflow)
    run({8'd127, 8'd0, 8'd22, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 4'd14, 4'd9, 4'd9, 4'd9, 0);
    run({8'd127, 8'd0, 8'd22, 8'd0, 8'd0, 8'd0, 8'd1}, 1'b1, 4'd14, 4'd14, 4'd14, 4'd14, 0);
    // 1*2 + 2*(-1) = 0: no minus sign for zero
    run({8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hFF, 8'd2}, 1'b0, 4'd14, 4'd0, 4'd0, 4'd0, 0);
    run({8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd105}, 1'b0, 4'd14, 4'd1, 4'd0, 4'd5, 10);

    // Reset mid-computation, then restart with indata1 = 7
    apply({8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd105});
    resetN = 1'b1;
    repeat (2) @(posedge clk);
    #1 resetN = 1'b0;
    repeat (11) @(posedge clk);
    #1 resetN = 1'b1;
    indata1 = 8'd7;
    @(posedge clk);
    #1 check_reset_vals("abort");
    begin
      exp_t ex;
      ex.err = 1'b0; ex.sg = 4'd14; ex.d1 = 4'd0; ex.d2 = 4'd0; ex.d3 = 4'd7; ex.cyc = 29;
      q.push_back(ex);
    end
    resetN = 1'b0;
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    chk("result_stable", {seven_seg_digit_1, seven_seg_digit_2, seven_seg_digit_3}, 12'h007);
    chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
